// File: rtl/fft_symbol_sched.sv
// FFT load sequencer: owns the input-buffer read pointer, skips guard intervals
// between data symbols, and produces the per-sample phase-correction word.
module fft_symbol_sched #(
  parameter int unsigned BUF_AW    = 8,
  parameter int unsigned FFT_LEN   = 64,
  parameter int unsigned PHASE_W   = 32,
  parameter int          PI        = 1608,
  parameter int          DOUBLE_PI = 3217
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               wr_stb,
  input  logic               start,
  input  logic [BUF_AW-1:0]  start_addr,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic               short_gi,
  input  logic               stop,
  input  logic               fft_rdy,
  output logic               rd_en,
  output logic [BUF_AW-1:0]  rd_addr,
  output logic               fft_start,
  output logic [PHASE_W-1:0] phase_corr,
  output logic [15:0]        symbol_idx,
  output logic               sym_done,
  output logic               busy
);

  localparam int unsigned OW = $clog2(FFT_LEN);
  localparam logic [OW-1:0]             LAST_OFFS = OW'(FFT_LEN - 1);
  localparam logic signed [15:0]        LOAD_LIM  = 16'(FFT_LEN);
  localparam logic signed [15:0]        OVR_LIM   = 16'((2 ** BUF_AW) - FFT_LEN);
  localparam logic signed [PHASE_W-1:0] PI_W      = PHASE_W'(PI);
  localparam logic signed [PHASE_W-1:0] DPI_W     = PHASE_W'(DOUBLE_PI);

  typedef enum logic [1:0] {IDLE, WAIT, LOAD} state_t;

  state_t                     state_q, state_d;
  logic                       rd_en_q, rd_en_d;
  logic                       fft_start_q, fft_start_d;
  logic                       sym_done_q, sym_done_d;
  logic [BUF_AW-1:0]          rd_addr_q, rd_addr_d;
  logic signed [PHASE_W-1:0]  phase_corr_q, phase_corr_d;
  logic signed [PHASE_W-1:0]  next_phase_q, next_phase_d;
  logic signed [PHASE_W-1:0]  offset_q, offset_d;
  logic [15:0]                symbol_idx_q, symbol_idx_d;
  logic [15:0]                produced_q, produced_d;
  logic [15:0]                consumed_q, consumed_d;
  logic [OW-1:0]              offs_q, offs_d;
  logic signed [15:0]         avail;
  logic [15:0]                gi_step;

  assign avail = produced_q - consumed_q;

  always_comb begin
    state_d      = state_q;
    rd_en_d      = rd_en_q;
    fft_start_d  = fft_start_q;
    sym_done_d   = sym_done_q;
    rd_addr_d    = rd_addr_q;
    phase_corr_d = phase_corr_q;
    next_phase_d = next_phase_q;
    offset_d     = offset_q;
    symbol_idx_d = symbol_idx_q;
    produced_d   = produced_q;
    consumed_d   = consumed_q;
    offs_d       = offs_q;
    // First LTS is followed directly by the second; data symbols carry a GI.
    gi_step      = (symbol_idx_q == '0) ? 16'd1 : (16'd1 + (short_gi ? 16'd8 : 16'd16));

    if (stop) begin
      state_d     = IDLE;
      rd_en_d     = 1'b0;
      fft_start_d = 1'b0;
      sym_done_d  = 1'b0;
    end else if (enable) begin
      fft_start_d = 1'b0;
      sym_done_d  = 1'b0;
      if ((state_q != IDLE) && wr_stb) produced_d = produced_q + 16'd1;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d      = WAIT;
            rd_addr_d    = start_addr;
            consumed_d   = '0;
            produced_d   = {15'd0, wr_stb};
            symbol_idx_d = '0;
            phase_corr_d = '0;
            next_phase_d = phase_offset;
            offset_d     = phase_offset;
            offs_d       = '0;
          end
        end
        WAIT: begin
          if (avail > OVR_LIM) begin
            state_d = IDLE;
          end else if ((avail > LOAD_LIM) && fft_rdy) begin
            state_d     = LOAD;
            rd_en_d     = 1'b1;
            fft_start_d = 1'b1;
            offs_d      = '0;
          end
        end
        LOAD: begin
          if (next_phase_q > PI_W) begin
            phase_corr_d = next_phase_q - DPI_W;
            next_phase_d = next_phase_q + offset_q - DPI_W;
          end else if (next_phase_q < -PI_W) begin
            phase_corr_d = next_phase_q + DPI_W;
            next_phase_d = next_phase_q + offset_q + DPI_W;
          end else begin
            phase_corr_d = next_phase_q;
            next_phase_d = next_phase_q + offset_q;
          end
          if (offs_q == LAST_OFFS) begin
            state_d      = WAIT;
            rd_en_d      = 1'b0;
            sym_done_d   = 1'b1;
            rd_addr_d    = rd_addr_q + gi_step[BUF_AW-1:0];
            consumed_d   = consumed_q + gi_step;
            offs_d       = '0;
            symbol_idx_d = (symbol_idx_q == '1) ? symbol_idx_q : symbol_idx_q + 16'd1;
          end else begin
            rd_addr_d  = rd_addr_q + BUF_AW'(1);
            consumed_d = consumed_q + 16'd1;
            offs_d     = offs_q + OW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      fft_start_q  <= 1'b0;
      sym_done_q   <= 1'b0;
      rd_addr_q    <= '0;
      phase_corr_q <= '0;
      next_phase_q <= '0;
      offset_q     <= '0;
      symbol_idx_q <= '0;
      produced_q   <= '0;
      consumed_q   <= '0;
      offs_q       <= '0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      fft_start_q  <= fft_start_d;
      sym_done_q   <= sym_done_d;
      rd_addr_q    <= rd_addr_d;
      phase_corr_q <= phase_corr_d;
      next_phase_q <= next_phase_d;
      offset_q     <= offset_d;
      symbol_idx_q <= symbol_idx_d;
      produced_q   <= produced_d;
      consumed_q   <= consumed_d;
      offs_q       <= offs_d;
    end
  end

  assign rd_en      = rd_en_q & enable;
  assign fft_start  = fft_start_q & enable;
  assign rd_addr    = rd_addr_q;
  assign phase_corr = phase_corr_q;
  assign symbol_idx = symbol_idx_q;
  assign sym_done   = sym_done_q;
  assign busy       = (state_q != IDLE);

endmodule
